// File: rtl/usb_tx.sv
// -----------------------------------------------------------------------------
// usb_tx -- USB full-speed style packet transmitter (token-less: handshake and
// data packets only).
//
// Sends SYNC, PID, optional payload and CRC16, then EOP, NRZI encoded with
// bit stuffing. One bit time is 8 clk cycles.
//
// Configuration macro:
//   USB_TX_CRC_EN  defined   -> CRC state and CRC16 generation compiled in.
//                  undefined -> no CRC field; DATA packets go straight to EOP.
//
// Ports:
//   clk                 in   system clock, rising edge
//   n_rst               in   synchronous active-low reset
//   tx_start            in   one-cycle send request (only honoured in IDLE)
//   tx_packet[3:0]      in   PID: DATA0/DATA1/ACK/NAK/STALL
//   buffer_occupancy[6:0] in payload byte count, latched with tx_start
//   tx_packet_data[7:0] in   show-ahead head byte of the TX buffer
//   get_tx_packet_data  out  one-cycle pop strobe, byte captured same cycle
//   dplus_out           out  D+ line
//   dminus_out          out  D- line
//   tx_transfer_active  out  high from first SYNC bit to last EOP J bit
//   tx_error            out  one-cycle pulse on a rejected request
// -----------------------------------------------------------------------------
module usb_tx (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [3:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_transfer_active,
   output logic       tx_error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      PID     = 3'd2,
      LOAD    = 3'd3,
      DATA    = 3'd4,
      CRC     = 3'd5,
      EOP_SE0 = 3'd6,
      EOP_J   = 3'd7
   } state_t;

   // Line pair encoding {dplus, dminus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   // NRZI: a logical 0 toggles the differential pair, a logical 1 holds it.
   function automatic logic [1:0] nrzi(input logic b, input logic [1:0] line);
      nrzi = b ? line : ~line;
   endfunction

`ifdef USB_TX_CRC_EN
   // One serial step of CRC16 (x^16+x^15+x^2+1), bits fed in wire order.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[15];
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction
`endif

   // Registers
   state_t      state_q;
   logic [2:0]  timer_q;      // position inside the current bit time
   logic [3:0]  bit_cnt_q;    // data bits already finished in current field
   logic [7:0]  shift_q;      // SYNC / PID / payload byte, LSB goes out first
   logic [2:0]  ones_q;       // consecutive logical ones before current bit
   logic        stuff_q;      // current bit time is a stuffed zero
   logic [6:0]  byte_cnt_q;   // payload bytes fetched so far
   logic [6:0]  len_q;        // payload length latched at start
   logic [3:0]  pid_q;
`ifdef USB_TX_CRC_EN
   logic [15:0] crc_q;
`endif
   logic        dplus_q;
   logic        dminus_q;
   logic        active_q;
   logic        get_q;
   logic        err_q;

   // Combinational helpers
   logic        cur_bit;      // logical bit on the wire right now
   logic        counting;     // current state takes part in bit stuffing
   logic [4:0]  field_len;
   logic [4:0]  sent;         // data bits of the field done once this bit ends
   logic [2:0]  ones_d;
   logic        stuff_ins;    // a stuffed zero must follow the current bit
   logic        field_done;
   logic        pid_is_data;
   logic        next_load;
   logic        start_ok;
   logic [7:0]  shift_d;
   logic        next_data_bit;
`ifdef USB_TX_CRC_EN
   logic [15:0] crc_d;
`endif

   assign get_tx_packet_data = get_q;
   assign dplus_out          = dplus_q;
   assign dminus_out         = dminus_q;
   assign tx_transfer_active = active_q;
   assign tx_error           = err_q;

   // Current-bit decode, stuffing decision and end-of-field detection.
   always_comb begin
      cur_bit   = 1'b0;
      counting  = 1'b0;
      field_len = 5'd8;
      case (state_q)
         SYNC, PID, DATA: begin
            cur_bit  = shift_q[0];
            counting = 1'b1;
         end
`ifdef USB_TX_CRC_EN
         CRC: begin
            cur_bit   = ~crc_q[15];
            counting  = 1'b1;
            field_len = 5'd16;
         end
`endif
         default: begin
            cur_bit  = 1'b0;
            counting = 1'b0;
         end
      endcase
      cur_bit     = stuff_q ? 1'b0 : cur_bit;
      ones_d      = cur_bit ? (ones_q + 3'd1) : 3'd0;
      stuff_ins   = counting && (ones_d == 3'd6);
      // A stuffed bit does not advance the field, so it adds nothing to sent.
      sent        = stuff_q ? {1'b0, bit_cnt_q} : ({1'b0, bit_cnt_q} + 5'd1);
      field_done  = counting && (sent == field_len) && !stuff_ins;
      pid_is_data = (pid_q == 4'b0011) || (pid_q == 4'b1011);
      next_load   = field_done && pid_is_data && (byte_cnt_q != len_q) &&
                    ((state_q == PID) || (state_q == DATA));
      start_ok    = ((tx_packet == 4'b0011) || (tx_packet == 4'b1011) ||
                     (tx_packet == 4'b0010) || (tx_packet == 4'b1010) ||
                     (tx_packet == 4'b1110)) && (buffer_occupancy <= 7'd64);
      shift_d     = stuff_q ? shift_q : {1'b0, shift_q[7:1]};
`ifdef USB_TX_CRC_EN
      if (stuff_q) begin
         crc_d = crc_q;
      end else if (state_q == DATA) begin
         crc_d = crc16_step(crc_q, shift_q[0]);
      end else if (state_q == CRC) begin
         crc_d = {crc_q[14:0], 1'b0};
      end else begin
         crc_d = crc_q;
      end
      next_data_bit = (state_q == CRC) ? ~crc_d[15] : shift_d[0];
`else
      next_data_bit = shift_d[0];
`endif
   end

   // Transmitter FSM with registered line, strobe and status outputs.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         timer_q    <= 3'd0;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         ones_q     <= 3'd0;
         stuff_q    <= 1'b0;
         byte_cnt_q <= 7'd0;
         len_q      <= 7'd0;
         pid_q      <= 4'd0;
`ifdef USB_TX_CRC_EN
         crc_q      <= 16'd0;
`endif
         dplus_q    <= 1'b1;
         dminus_q   <= 1'b0;
         active_q   <= 1'b0;
         get_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         get_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               timer_q <= 3'd0;
               if (tx_start) begin
                  if (start_ok) begin
                     state_q    <= SYNC;
                     shift_q    <= 8'h80;
                     bit_cnt_q  <= 4'd0;
                     ones_q     <= 3'd0;
                     stuff_q    <= 1'b0;
                     byte_cnt_q <= 7'd0;
                     len_q      <= buffer_occupancy;
                     pid_q      <= tx_packet;
`ifdef USB_TX_CRC_EN
                     crc_q      <= 16'hFFFF;
`endif
                     active_q   <= 1'b1;
                     // First SYNC bit is a 0: J -> K.
                     {dplus_q, dminus_q} <= nrzi(1'b0, LINE_J);
                  end else begin
                     err_q <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end

            // LOAD occupies the last cycle of the preceding bit time, so the
            // fetch costs no time on the wire.
            LOAD: begin
               timer_q    <= timer_q + 3'd1;
               state_q    <= DATA;
               shift_q    <= tx_packet_data;
               bit_cnt_q  <= 4'd0;
               stuff_q    <= 1'b0;
               byte_cnt_q <= byte_cnt_q + 7'd1;
               {dplus_q, dminus_q} <= nrzi(tx_packet_data[0], {dplus_q, dminus_q});
            end

            SYNC, PID, DATA, CRC: begin
               timer_q <= timer_q + 3'd1;
               if ((timer_q == 3'd6) && next_load) begin
                  // Retire the final bit early and fetch the next byte.
                  shift_q <= shift_d;
`ifdef USB_TX_CRC_EN
                  crc_q   <= crc_d;
`endif
                  ones_q  <= ones_d;
                  stuff_q <= 1'b0;
                  state_q <= LOAD;
                  get_q   <= 1'b1;
               end else if (timer_q == 3'd7) begin
                  shift_q <= shift_d;
`ifdef USB_TX_CRC_EN
                  crc_q   <= crc_d;
`endif
                  ones_q  <= ones_d;
                  if (!stuff_q) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q;
                  end
                  if (stuff_ins) begin
                     stuff_q <= 1'b1;
                     {dplus_q, dminus_q} <= nrzi(1'b0, {dplus_q, dminus_q});
                  end else if (!field_done) begin
                     stuff_q <= 1'b0;
                     {dplus_q, dminus_q} <= nrzi(next_data_bit, {dplus_q, dminus_q});
                  end else begin
                     stuff_q   <= 1'b0;
                     bit_cnt_q <= 4'd0;
                     case (state_q)
                        SYNC: begin
                           state_q <= PID;
                           shift_q <= {~pid_q, pid_q};
                           {dplus_q, dminus_q} <= nrzi(pid_q[0], {dplus_q, dminus_q});
                        end
`ifdef USB_TX_CRC_EN
                        PID, DATA: begin
                           if (pid_is_data) begin
                              state_q <= CRC;
                              {dplus_q, dminus_q} <= nrzi(~crc_d[15], {dplus_q, dminus_q});
                           end else begin
                              state_q <= EOP_SE0;
                              {dplus_q, dminus_q} <= LINE_SE0;
                           end
                        end
`endif
                        default: begin
                           state_q <= EOP_SE0;
                           {dplus_q, dminus_q} <= LINE_SE0;
                        end
                     endcase
                  end
               end else begin
                  state_q <= state_q;
               end
            end

            EOP_SE0: begin
               timer_q <= timer_q + 3'd1;
               if (timer_q == 3'd7) begin
                  if (bit_cnt_q == 4'd1) begin
                     state_q   <= EOP_J;
                     bit_cnt_q <= 4'd0;
                     {dplus_q, dminus_q} <= LINE_J;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  state_q <= EOP_SE0;
               end
            end

            EOP_J: begin
               timer_q <= timer_q + 3'd1;
               if (timer_q == 3'd7) begin
                  state_q  <= IDLE;
                  active_q <= 1'b0;
                  {dplus_q, dminus_q} <= LINE_J;
               end else begin
                  state_q <= EOP_J;
               end
            end

            default: begin
               state_q  <= IDLE;
               active_q <= 1'b0;
               {dplus_q, dminus_q} <= LINE_J;
            end
         endcase
      end
   end

endmodule
